// File: rtl/timer_pkg.sv
// Shared types for the timer/counter family.
// Exports mode_e, the count mode selector driven by the register interface.
package timer_pkg;

  // Count modes: periodic up, periodic down, up/down triangle, one-shot up.
  typedef enum logic [1:0] {
    MODE_UP      = 2'd0,
    MODE_DOWN    = 2'd1,
    MODE_UPDN    = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_e;

  localparam int unsigned MODE_WIDTH = 2;

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler producing one tick every div_i+1 enabled cycles.
// Ports:
//   clk_i, rst_n_i : clock, async active-low reset
//   clr_i          : sync restart of the divider (psc=0)
//   en_i           : advance enable; divider holds when low
//   div_i          : divide value, tick when psc == div_i
//   tick_o         : combinational tick, valid in the cycle it is consumed
module tick_prescaler #(
  parameter int unsigned PSC_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [PSC_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [PSC_WIDTH-1:0] psc_q;
  logic [PSC_WIDTH-1:0] psc_d;

  // Equality (not >=): lowering div_i below psc makes psc wrap through max.
  assign tick_o = en_i && (psc_q == div_i);

  // Next prescaler value.
  always_comb begin
    psc_d = psc_q;
    if (clr_i) begin
      psc_d = '0;
    end else if (tick_o) begin
      psc_d = '0;
    end else if (en_i) begin
      psc_d = psc_q + PSC_WIDTH'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end

endmodule

// File: rtl/reload_counter.sv
// General-purpose reload counter: prescaled tick, four count modes,
// compare pulse and PWM level.
// Ports:
//   clk_i, rst_n_i : clock, async active-low reset
//   clr_i          : sync clear (cnt=0, psc=0, dir=up, done=0)
//   en_i           : count enable, gates the prescaler
//   load_i, dat_i  : sync load of the count (dir unchanged)
//   mode_i         : mode_e count mode
//   psc_i          : prescaler divide (tick every psc_i+1 enabled cycles)
//   reload_i       : period end / down-count restart value
//   cmp_i          : compare value
//   dat_o, dir_o   : registered count and direction (1 = down)
//   ovf_o, cmp_o   : registered one-cycle period-end and compare pulses
//   pwm_o          : dat_o < cmp_i
//   busy_o         : en_i && !done
module reload_counter
  import timer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PSC_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic                  load_i,
  input  logic [MODE_WIDTH-1:0] mode_i,
  input  logic [PSC_WIDTH-1:0]  psc_i,
  input  logic [DATA_WIDTH-1:0] reload_i,
  input  logic [DATA_WIDTH-1:0] cmp_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  dir_o,
  output logic                  ovf_o,
  output logic                  cmp_o,
  output logic                  pwm_o,
  output logic                  busy_o
);

  mode_e                 mode;
  logic                  tick;
  logic                  at_top;
  logic                  at_zero;

  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic                  dir_q, dir_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  cmp_q, cmp_d;

  assign mode    = mode_e'(mode_i);
  assign at_top  = (cnt_q >= reload_i);
  assign at_zero = (cnt_q == '0);

  // A finished one-shot stops the prescaler; clr/load restart it from zero.
  tick_prescaler #(
    .PSC_WIDTH (PSC_WIDTH)
  ) u_psc (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (clr_i || load_i),
    .en_i    (en_i && !done_q),
    .div_i   (psc_i),
    .tick_o  (tick)
  );

  // Next-state logic: clear > load > tick; pulses default low.
  always_comb begin
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    done_d = done_q;
    ovf_d  = 1'b0;
    cmp_d  = 1'b0;
    if (clr_i) begin
      cnt_d  = '0;
      dir_d  = 1'b0;
      done_d = 1'b0;
    end else if (load_i) begin
      cnt_d  = dat_i;
      done_d = 1'b0;
    end else if (tick) begin
      case (mode)
        MODE_UP: begin
          dir_d = 1'b0;
          if (at_top) begin
            cnt_d = '0;
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + DATA_WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          dir_d = 1'b1;
          if (at_zero) begin
            cnt_d = reload_i;
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q - DATA_WIDTH'(1);
          end
        end
        MODE_UPDN: begin
          // Zero period degenerates to a constant zero count, turnaround every tick.
          if (reload_i == '0) begin
            cnt_d = '0;
            dir_d = 1'b0;
            ovf_d = 1'b1;
          end else if (!dir_q) begin
            if (at_top) begin
              dir_d = 1'b1;
              cnt_d = cnt_q - DATA_WIDTH'(1);
              ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q + DATA_WIDTH'(1);
            end
          end else begin
            if (at_zero) begin
              dir_d = 1'b0;
              cnt_d = DATA_WIDTH'(1);
              ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q - DATA_WIDTH'(1);
            end
          end
        end
        MODE_ONESHOT: begin
          dir_d = 1'b0;
          if (at_top) begin
            done_d = 1'b1;
            ovf_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + DATA_WIDTH'(1);
          end
        end
      endcase
      cmp_d = (cnt_d == cmp_i);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      cmp_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
      cmp_q  <= cmp_d;
    end
  end

  assign dat_o  = cnt_q;
  assign dir_o  = dir_q;
  assign ovf_o  = ovf_q;
  assign cmp_o  = cmp_q;
  assign pwm_o  = (cnt_q < cmp_i);
  assign busy_o = en_i && !done_q;

endmodule

// File: tb/tb_reload_counter.sv
// Self-checking bench for reload_counter: directed literal sequences plus
// randomized stimulus compared every cycle against a behavioural model.
module tb_reload_counter;
  import timer_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned PW = 8;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          clr    = 1'b0;
  logic          en     = 1'b0;
  logic          load   = 1'b0;
  logic [1:0]    mode   = 2'd0;
  logic [PW-1:0] psc    = '0;
  logic [DW-1:0] reload = '0;
  logic [DW-1:0] cmpv   = '0;
  logic [DW-1:0] dat    = '0;

  logic [DW-1:0] dat_o;
  logic          dir_o, ovf_o, cmp_o, pwm_o, busy_o;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  reload_counter #(.DATA_WIDTH(DW), .PSC_WIDTH(PW)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .clr_i    (clr),
    .en_i     (en),
    .load_i   (load),
    .mode_i   (mode),
    .psc_i    (psc),
    .reload_i (reload),
    .cmp_i    (cmpv),
    .dat_i    (dat),
    .dat_o    (dat_o),
    .dir_o    (dir_o),
    .ovf_o    (ovf_o),
    .cmp_o    (cmp_o),
    .pwm_o    (pwm_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int n;
    bit d;
    bit dn;
    bit o;
  } nxt_t;

  // Count rule applied on a tick, written directly from the mode descriptions.
  function automatic nxt_t step(input int cnt, input bit dir, input int md, input int rl);
    nxt_t r;
    r.n = cnt; r.d = dir; r.dn = 1'b0; r.o = 1'b0;
    case (md)
      0: begin
        r.d = 1'b0;
        if (cnt >= rl) begin r.n = 0; r.o = 1'b1; end else r.n = cnt + 1;
      end
      1: begin
        r.d = 1'b1;
        if (cnt == 0) begin r.n = rl; r.o = 1'b1; end else r.n = cnt - 1;
      end
      2: begin
        if (rl == 0) begin
          r.n = 0; r.d = 1'b0; r.o = 1'b1;
        end else if (!dir) begin
          if (cnt >= rl) begin r.d = 1'b1; r.n = cnt - 1; r.o = 1'b1; end
          else r.n = cnt + 1;
        end else begin
          if (cnt == 0) begin r.d = 1'b0; r.n = 1; r.o = 1'b1; end
          else r.n = cnt - 1;
        end
      end
      default: begin
        r.d = 1'b0;
        if (cnt >= rl) begin r.dn = 1'b1; r.o = 1'b1; end else r.n = cnt + 1;
      end
    endcase
    return r;
  endfunction

  int   m_cnt = 0;
  int   m_psc = 0;
  bit   m_dir = 1'b0;
  bit   m_done = 1'b0;
  bit   m_ovf = 1'b0;
  bit   m_cmp = 1'b0;
  bit   m_tick;
  nxt_t m_nx;

  always_comb begin
    m_tick = en && !m_done && (m_psc == int'(psc));
    m_nx   = step(m_cnt, m_dir, int'(mode), int'(reload));
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_psc <= 0; m_dir <= 1'b0; m_done <= 1'b0; m_ovf <= 1'b0; m_cmp <= 1'b0;
    end else if (clr) begin
      m_cnt <= 0; m_psc <= 0; m_dir <= 1'b0; m_done <= 1'b0; m_ovf <= 1'b0; m_cmp <= 1'b0;
    end else if (load) begin
      m_cnt <= int'(dat); m_psc <= 0; m_done <= 1'b0; m_ovf <= 1'b0; m_cmp <= 1'b0;
    end else begin
      if (en) m_psc <= m_tick ? 0 : (m_psc + 1) % 256;
      if (m_tick) begin
        m_cnt  <= m_nx.n;
        m_dir  <= m_nx.d;
        m_done <= m_nx.dn;
        m_ovf  <= m_nx.o;
        m_cmp  <= (m_nx.n == int'(cmpv));
      end else begin
        m_ovf <= 1'b0;
        m_cmp <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("model_dat", 32'(dat_o), 32'(m_cnt));
      check("model_dir", 32'(dir_o), 32'(m_dir));
      check("model_ovf", 32'(ovf_o), 32'(m_ovf));
      check("model_cmp", 32'(cmp_o), 32'(m_cmp));
      check("model_pwm", 32'(pwm_o), 32'(m_cnt < int'(cmpv)));
      check("model_busy", 32'(busy_o), 32'(en && !m_done));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] up_seq [5];
    logic [DW-1:0] dn_seq [12];
    logic [DW-1:0] ud_seq [6];
    logic          ud_dir [6];
    logic [DW-1:0] os_seq [6];
    up_seq = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
    dn_seq = '{16'd0, 16'd0, 16'd2, 16'd2, 16'd2, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd2};
    ud_seq = '{16'd1, 16'd2, 16'd1, 16'd0, 16'd1, 16'd2};
    ud_dir = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    os_seq = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd4, 16'd4};

    // Reset state
    cmpv = 16'd5;
    #12;
    check("rst_dat", 32'(dat_o), 32'd0);
    check("rst_ovf", 32'(ovf_o), 32'd0);
    check("rst_cmp", 32'(cmp_o), 32'd0);
    check("rst_dir", 32'(dir_o), 32'd0);
    check("rst_pwm", 32'(pwm_o), 32'd1);
    check("rst_busy_off", 32'(busy_o), 32'd0);
    en = 1'b1;
    #1;
    check("rst_busy_on", 32'(busy_o), 32'd1);
    rst_n = 1'b1;
    chk_on = 1'b1;
    cyc();

    // UP, psc 0, reload 3, cmp 2
    mode = 2'(MODE_UP); psc = '0; reload = 16'd3; cmpv = 16'd2;
    do_clr();
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("up_dat", 32'(dat_o), 32'(up_seq[i]));
      check("up_ovf", 32'(ovf_o), 32'(i == 3));
      check("up_cmp", 32'(cmp_o), 32'(i == 1));
    end

    // DOWN, psc 2, reload 2
    mode = 2'(MODE_DOWN); psc = 8'd2; reload = 16'd2; cmpv = 16'd9;
    do_clr();
    for (int i = 0; i < 12; i++) begin
      cyc();
      check("down_dat", 32'(dat_o), 32'(dn_seq[i]));
      check("down_ovf", 32'(ovf_o), 32'(i == 2 || i == 11));
      if (i == 2) check("down_dir", 32'(dir_o), 32'd1);
    end

    // UPDN, psc 0, reload 2
    mode = 2'(MODE_UPDN); psc = '0; reload = 16'd2; cmpv = 16'd7;
    do_clr();
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("updn_dat", 32'(dat_o), 32'(ud_seq[i]));
      check("updn_dir", 32'(dir_o), 32'(ud_dir[i]));
      check("updn_ovf", 32'(ovf_o), 32'(i == 2 || i == 4));
    end

    // ONESHOT, reload 4, then load restart at 1
    mode = 2'(MODE_ONESHOT); reload = 16'd4;
    do_clr();
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("os_dat", 32'(dat_o), 32'(os_seq[i]));
      check("os_ovf", 32'(ovf_o), 32'(i == 4));
      check("os_busy", 32'(busy_o), 32'(i < 4));
    end
    load = 1'b1; dat = 16'd1;
    cyc();
    load = 1'b0;
    check("os_load_dat", 32'(dat_o), 32'd1);
    check("os_load_busy", 32'(busy_o), 32'd1);
    cyc();
    check("os_restart_dat", 32'(dat_o), 32'd2);

    // clr and load together at a tick
    mode = 2'(MODE_UP); reload = 16'd100; cmpv = 16'd0;
    clr = 1'b1; load = 1'b1; dat = 16'd9;
    cyc();
    clr = 1'b0; load = 1'b0;
    check("clrld_dat", 32'(dat_o), 32'd0);
    check("clrld_ovf", 32'(ovf_o), 32'd0);
    check("clrld_cmp", 32'(cmp_o), 32'd0);

    // en low freezes count and prescaler
    psc = 8'd1; cmpv = 16'd50;
    do_clr();
    cyc(2);
    check("frz_start", 32'(dat_o), 32'd1);
    cyc();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("frz_hold", 32'(dat_o), 32'd1);
    end
    en = 1'b1;
    cyc();
    check("frz_resume", 32'(dat_o), 32'd2);

    // Reload lowered below the running count
    psc = '0; reload = 16'd12;
    load = 1'b1; dat = 16'd10;
    cyc();
    load = 1'b0;
    check("rl_dat10", 32'(dat_o), 32'd10);
    reload = 16'd5;
    cyc();
    check("rl_wrap_dat", 32'(dat_o), 32'd0);
    check("rl_wrap_ovf", 32'(ovf_o), 32'd1);

    // Async reset mid-count
    reload = 16'd100; mode = 2'(MODE_DOWN);
    do_clr();
    cyc(3);
    #1 rst_n = 1'b0;
    #1;
    check("arst_dat", 32'(dat_o), 32'd0);
    check("arst_dir", 32'(dir_o), 32'd0);
    check("arst_ovf", 32'(ovf_o), 32'd0);
    check("arst_pwm", 32'(pwm_o), 32'd1);
    #1 rst_n = 1'b1;
    cyc();

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      en   = ($urandom_range(0, 99) < 90);
      clr  = ($urandom_range(0, 99) < 2);
      load = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 3) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 5) psc = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 999) < 2) psc = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) < 5) reload = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 5) cmpv = 16'($urandom_range(0, 16));
      dat = ($urandom_range(0, 99) < 5) ? 16'($urandom) : 16'($urandom_range(0, 20));
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      cyc();
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
